// File: rtl/mux_sel_pkg.sv
//==============================================================================
// Module      : mux_sel_pkg
// Description : Shared types, defaults and helpers for the mux select arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mux_sel_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Default channel count (matches the 4:1 mux) and burst cap
    localparam int NUM_CH_DEF    = 4;
    localparam int MAX_BURST_DEF = 4;

    // Index of the set bit in a one-hot vector (highest set bit if not one-hot)
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick.sv
//==============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority finder. Scans req starting at
//               index 'start' and wrapping modulo NUM_CH; reports the first
//               set bit found.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick
    import mux_sel_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  start,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] cand;

    // Walk the channels in rotated order; NUM_CH is a power of two so the
    // SEL_W-bit addition wraps naturally.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = start + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
//==============================================================================
// Module      : mux_sel_arbiter
// Description : Round-robin arbiter producing a registered one-hot grant and a
//               binary select for a NUM_CH:1 mux, with a per-owner burst cap.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int SEL_W     = $clog2(NUM_CH),
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              req,
    output logic [SEL_W-1:0]               sel,
    output logic [NUM_CH-1:0]              gnt,
    output logic                           gnt_valid,
    output logic [$clog2(MAX_BURST+1)-1:0] burst_cnt
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   ptr, ptr_nx;
    logic [SEL_W-1:0]   sel_nx;
    logic [NUM_CH-1:0]  gnt_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               take;
    logic               own;
    logic [NUM_CH-1:0]  others;
    logic               found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   start;

    // The owner is masked out so 'found' means "someone else is waiting".
    // ptr always equals the current owner while granted, so ptr+1 is also
    // the o+1 search origin used for rotation and handover.
    assign others = req & ~gnt;
    assign own    = |(req & gnt);
    assign start  = ptr + SEL_W'(1);

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req    (others),
        .start  (start),
        .found  (found),
        .idx    (pick_idx)
    );

    // Next-state and next-output decode
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        gnt_nx   = gnt;
        cnt_nx   = burst_cnt;
        take     = 1'b0;

        case (state)
            IDLE: begin
                if (found) take = 1'b1;
            end
            GRANT: begin
                if (own && (burst_cnt < CNT_MAX)) begin
                    cnt_nx = burst_cnt + CNT_ONE;
                end else if (own) begin
                    // Burst exhausted: rotate only if there is competition,
                    // otherwise restart the count and keep the grant.
                    if (found) take = 1'b1;
                    else       cnt_nx = CNT_ONE;
                end else if (found) begin
                    take = 1'b1;
                end else begin
                    // Release; sel keeps the last owner so the mux is stable
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (take) begin
            gnt_nx           = '0;
            gnt_nx[pick_idx] = 1'b1;
            sel_nx           = pick_idx;
            ptr_nx           = pick_idx;
            cnt_nx           = CNT_ONE;
            state_nx         = GRANT;
        end
    end

    // State and registered outputs; reset leaves channel 0 highest priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= SEL_W'(NUM_CH - 1);
            sel       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            sel       <= sel_nx;
            gnt       <= gnt_nx;
            gnt_valid <= |gnt_nx;
            burst_cnt <= cnt_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
//==============================================================================
// Module      : tb_mux_sel_arbiter
// Description : Scoreboard bench for mux_sel_arbiter with directed vectors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux_sel_arbiter;
    import mux_sel_pkg::*;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       gv;
        logic [2:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [2:0] burst_cnt;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   vec;
    logic kick;

    mux_sel_arbiter #(
        .NUM_CH    (4),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%0h exp=%0h", name, vec, act, exp);
        end
    endtask

    // Monitor: after every rising edge (or an explicit async sample request)
    // pop the next expectation and compare it to the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or kick);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vec++;
                check("gnt",       int'(gnt),       int'(e.gnt));
                check("sel",       int'(sel),       int'(e.sel));
                check("gnt_valid", int'(gnt_valid), int'(e.gv));
                check("burst_cnt", int'(burst_cnt), int'(e.cnt));
                if (gnt_valid)
                    check("sel_vs_gnt", int'(sel), int'(onehot_to_idx({28'd0, gnt})));
            end
        end
    end

    // Drive req at a falling edge and queue the outputs expected after the
    // following rising edge.
    task automatic step(input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] es, input logic [2:0] ec);
        exp_t e;
        req   = r;
        e.gnt = eg;
        e.sel = es;
        e.gv  = |eg;
        e.cnt = ec;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vec    = 0;
        kick   = 1'b0;
        rst_n  = 1'b0;
        req    = 4'b1111;
        @(negedge clk);

        // Held in reset with all requests
        step(4'b1111, 4'b0000, 2'd0, 3'd0);
        step(4'b1111, 4'b0000, 2'd0, 3'd0);

        // Release: channel 0 first, capped at 4 then rotate to ch1
        rst_n = 1'b1;
        step(4'b1111, 4'b0001, 2'd0, 3'd1);
        step(4'b1111, 4'b0001, 2'd0, 3'd2);
        step(4'b1111, 4'b0001, 2'd0, 3'd3);
        step(4'b1111, 4'b0001, 2'd0, 3'd4);
        step(4'b1111, 4'b0010, 2'd1, 3'd1);

        // Release to idle; sel holds 1
        step(4'b0000, 4'b0000, 2'd1, 3'd0);

        // Burst cap between ch0 and ch1, no gap cycle
        step(4'b0011, 4'b0001, 2'd0, 3'd1);
        step(4'b0011, 4'b0001, 2'd0, 3'd2);
        step(4'b0011, 4'b0001, 2'd0, 3'd3);
        step(4'b0011, 4'b0001, 2'd0, 3'd4);
        step(4'b0011, 4'b0010, 2'd1, 3'd1);
        step(4'b0011, 4'b0010, 2'd1, 3'd2);
        step(4'b0011, 4'b0010, 2'd1, 3'd3);
        step(4'b0011, 4'b0010, 2'd1, 3'd4);
        step(4'b0011, 4'b0001, 2'd0, 3'd1);

        // Sole requester ch2 for 10 cycles; count wraps without release
        for (int i = 0; i < 10; i++)
            step(4'b0100, 4'b0100, 2'd2, 3'((i % 4) + 1));

        // Owner drops, ch0 and ch3 waiting: search from 3 picks ch3
        step(4'b1001, 4'b1000, 2'd3, 3'd1);

        // Idle hold: sel stays 3, then regrant after one cycle
        step(4'b0000, 4'b0000, 2'd3, 3'd0);
        step(4'b0000, 4'b0000, 2'd3, 3'd0);
        step(4'b1000, 4'b1000, 2'd3, 3'd1);

        // Non-owner toggling has no effect until the burst cap
        step(4'b1010, 4'b1000, 2'd3, 3'd2);
        step(4'b1100, 4'b1000, 2'd3, 3'd3);
        step(4'b1001, 4'b1000, 2'd3, 3'd4);
        step(4'b1010, 4'b0010, 2'd1, 3'd1);
        step(4'b0010, 4'b0010, 2'd1, 3'd2);

        // Asynchronous reset between edges while ch1 owns the grant
        #2;
        rst_n = 1'b0;
        exp_q.push_back(exp_t'{gnt: 4'b0000, sel: 2'd0, gv: 1'b0, cnt: 3'd0});
        kick = ~kick;
        @(negedge clk);
        step(4'b0010, 4'b0000, 2'd0, 3'd0);
        rst_n = 1'b1;
        step(4'b0010, 4'b0010, 2'd1, 3'd1);

        // Second reset: ptr restarts at 3, so ch0 beats ch1
        rst_n = 1'b0;
        step(4'b0011, 4'b0000, 2'd0, 3'd0);
        rst_n = 1'b1;
        step(4'b0011, 4'b0001, 2'd0, 3'd1);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that drives the select of the team's 4:1 mux.
- Takes per-channel requests and issues a registered one-hot grant plus a binary select.
- The select is ready to connect directly to the mux `sel` input, so only the granted source reaches the mux output.
- Caps each grant at a burst length so no channel can starve the others.

Parameters:
- NUM_CH, 4, number of request channels; must be a power of two, >= 2 (4 for the 4:1 mux).
- SEL_W, $clog2(NUM_CH), select width; derived, do not override.
- MAX_BURST, 4, maximum consecutive granted cycles per channel while another channel is requesting; >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_CH  per-channel request, level-sensitive; bit i = channel i.
- sel  output  SEL_W  registered binary index of the granted channel; drives the mux select.
- gnt  output  NUM_CH  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  registered; high while any grant is active (equals |gnt).
- burst_cnt  output  $clog2(MAX_BURST+1)  registered count of granted cycles for the current owner (debug/observe).

Behaviour:
- One clock; reset is asynchronous and active-low; all state is updated on the rising edge of clk.
- Reset values:
  - sel=0, gnt=0, gnt_valid=0, burst_cnt=0.
  - Internal last-granted pointer ptr=NUM_CH-1, so channel 0 has top priority after reset.
  - State=IDLE.
- Reset asserted mid-grant clears everything immediately. No grant persists across reset.
- Priority search: rotating, starts at ptr+1 and wraps modulo NUM_CH. The first set req bit in that order wins.
- State IDLE:
  - If req==0: stay IDLE; sel holds its last value so the mux input stays stable; gnt=0.
  - If req!=0: at the next edge gnt=onehot(winner), sel=winner, burst_cnt=1, ptr=winner, go to GRANT.
  - Latency from req rising to gnt high is exactly 1 cycle.
- State GRANT, owner o=sel, evaluated each edge:
  - a) req[o]=1, burst_cnt<MAX_BURST: keep the grant; burst_cnt+1.
  - b) req[o]=1, burst_cnt==MAX_BURST, other requests pending: rotate to the next winner searched from o+1; burst_cnt=1; ptr=new winner. No idle bubble.
  - c) req[o]=1, burst_cnt==MAX_BURST, no other request: keep the grant; burst_cnt=1 (wrap, no forced release).
  - d) req[o]=0, other requests pending: hand over to the next winner from o+1 in the same edge; burst_cnt=1. No bubble.
  - e) req[o]=0, no other request: gnt=0, gnt_valid=0, burst_cnt=0, go IDLE; sel holds o.
- burst_cnt never exceeds MAX_BURST. For MAX_BURST=1, every cycle with competing requests rotates.
- Simultaneous requests from several channels: exactly one grant, chosen by the rotation rule. gnt is always one-hot or zero (never multi-hot).
- req bits toggling on a non-owner during a grant have no effect until a release or rotation point.
- Invariants:
  - sel==index(gnt) whenever gnt_valid=1.
  - gnt_valid==|gnt at all times.

Decomposition:
- Package mux_sel_pkg:
  - state enum {IDLE, GRANT}.
  - Constants NUM_CH_DEF=4 and MAX_BURST_DEF=4.
  - Function onehot_to_idx.
- Sub-module rr_pick: purely combinational rotating-priority finder.
  - Inputs: req[NUM_CH], start[SEL_W].
  - Outputs: found, idx[SEL_W].
  - Instantiated once; the top handles all registers and the FSM.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, sel=0, gnt_valid=0. Release; next edge -> gnt=4'b0001, sel=0.
- Burst cap: req=4'b0011 held, MAX_BURST=4 -> ch0 granted 4 cycles (burst_cnt 1..4), then ch1 for 4 cycles, then ch0, with no gap cycle.
- Sole requester: req=4'b0100 held 10 cycles -> gnt=4'b0100 continuously; burst_cnt runs 1,2,3,4,1,2,...
- Early release/handover: ch2 owns the grant, req changes 4'b0100 -> 4'b1001 -> next edge gnt=4'b1000 (search starts at 3), sel=3.
- Idle hold: owner ch3 drops req and req=0 -> gnt=0, gnt_valid=0, sel stays 3. Then req=4'b1000 -> regranted after 1 cycle.
- Mid-grant reset: pulse rst_n low asynchronously between edges while ch1 is granted -> outputs clear immediately. After release with req=4'b0010 -> ch1 regranted, ptr restarted from NUM_CH-1.
